// File: rtl/fc_classifier_if.sv
// Streaming-sample, weight-load and result signals of the fully-connected digit classifier.
interface fc_classifier_if #(
    parameter int W1    = 9,
    parameter int WW    = 8,
    parameter int ACC_W = 24
);
    logic signed [W1-1:0]    din;
    logic                    din_valid;
    logic                    w_we;
    logic [8:0]              w_addr;
    logic signed [WW-1:0]    w_data;
    logic                    busy;
    logic [3:0]              class_out;
    logic signed [ACC_W-1:0] score_out;
    logic                    done;

    modport master (
        output din, din_valid, w_we, w_addr, w_data,
        input  busy, class_out, score_out, done
    );

    modport slave (
        input  din, din_valid, w_we, w_addr, w_data,
        output busy, class_out, score_out, done
    );
endinterface

// File: rtl/fc_classifier.sv
// Fully-connected 49-input / 10-class layer with a serial argmax over the class scores.
// Define FC_BIAS_EN to add per-class bias registers at weight addresses N_CLS*N_IN and up.
module fc_classifier #(
    parameter int W1    = 9,
    parameter int WW    = 8,
    parameter int ACC_W = 24,
    parameter int N_IN  = 49,
    parameter int N_CLS = 10
) (
    input logic            clk,
    input logic            rst,
    fc_classifier_if.slave bus
);
    localparam int KW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW  = W1 + WW;
    localparam int N_W = N_CLS * N_IN;

    typedef enum logic [1:0] {IDLE, ACC, ARGMAX, DONE} state_t;

    state_t                  state, state_nx;
    logic signed [WW-1:0]    w_mem [N_CLS][N_IN];
    logic signed [ACC_W-1:0] acc   [N_CLS];
    logic signed [ACC_W-1:0] init  [N_CLS];
    logic signed [PW-1:0]    prod  [N_CLS];
    logic signed [ACC_W-1:0] prod_ext [N_CLS];
    logic [KW-1:0]           k;
    logic                    frame_full;
    logic                    sample_take, last_take;
    logic                    wr_hit;
    logic [3:0]              wr_cls;
    logic [KW-1:0]           wr_idx;
    logic [3:0]              idx, best_idx, win_idx;
    logic signed [ACC_W-1:0] best_val, win_val;
    logic [3:0]              class_q;
    logic signed [ACC_W-1:0] score_q;

    // frame_full marks that all N_IN samples are in; ACC then moves on to ARGMAX one edge later.
    assign sample_take = bus.din_valid && (state == IDLE || (state == ACC && !frame_full));
    assign last_take   = sample_take && (k == KW'(N_IN - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_hit = 1'b0;
        wr_cls = '0;
        wr_idx = '0;
        for (int c = 0; c < N_CLS; c++) begin
            if (int'(bus.w_addr) >= c * N_IN && int'(bus.w_addr) < (c + 1) * N_IN) begin
                wr_hit = 1'b1;
                wr_cls = 4'(c);
                wr_idx = KW'(int'(bus.w_addr) - c * N_IN);
            end
        end
    end

    // NOTE: the weight RAM is deliberately not reset; it keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (bus.w_we && state == IDLE && wr_hit)
            w_mem[wr_cls][wr_idx] <= bus.w_data;
    end

`ifdef FC_BIAS_EN
    logic signed [WW-1:0] bias [N_CLS];
    logic                 bias_hit;
    logic [3:0]           bias_sel;

    assign bias_hit = int'(bus.w_addr) >= N_W && int'(bus.w_addr) < N_W + N_CLS;
    assign bias_sel = 4'(int'(bus.w_addr) - N_W);

    always_ff @(posedge clk) begin
        if (bus.w_we && state == IDLE && bias_hit)
            bias[bias_sel] <= bus.w_data;
    end

    always_comb begin
        for (int c = 0; c < N_CLS; c++) init[c] = ACC_W'(bias[c]);
    end
`else
    always_comb begin
        for (int c = 0; c < N_CLS; c++) init[c] = '0;
    end
`endif

    // k is 0 in IDLE, so the same product path serves the first sample and the rest.
    always_comb begin
        for (int c = 0; c < N_CLS; c++) begin
            prod[c]     = bus.din * w_mem[c][k];
            prod_ext[c] = ACC_W'(prod[c]);
        end
    end

    always_comb begin
        win_idx = best_idx;
        win_val = best_val;
        if (idx == 4'd0 || acc[idx] > best_val) begin
            win_idx = idx;
            win_val = acc[idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.din_valid) state_nx = ACC;
            ACC:     if (frame_full) state_nx = ARGMAX;
            ARGMAX:  if (idx == 4'(N_CLS - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == ACC) || (state == ARGMAX);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CLS; c++) acc[c] <= '0;
            k          <= '0;
            frame_full <= 1'b0;
            idx        <= '0;
            best_idx   <= '0;
            best_val   <= '0;
            class_q    <= '0;
            score_q    <= '0;
        end else begin
            if (sample_take) begin
                for (int c = 0; c < N_CLS; c++)
                    acc[c] <= ((state == IDLE) ? init[c] : acc[c]) + prod_ext[c];
                k <= last_take ? '0 : k + 1'b1;
            end
            if (last_take)
                frame_full <= 1'b1;
            else if (state != ACC)
                frame_full <= 1'b0;

            if (state == ARGMAX) begin
                best_idx <= win_idx;
                best_val <= win_val;
                idx      <= idx + 1'b1;
                if (idx == 4'(N_CLS - 1)) begin
                    class_q <= win_idx;
                    score_q <= win_val;
                end
            end else begin
                idx <= '0;
            end
        end
    end

    assign bus.class_out = class_q;
    assign bus.score_out = score_q;
endmodule

// File: tb/tb_fc_classifier.sv
// Randomised self-checking bench for fc_classifier against a sum-of-products / argmax model.
module tb_fc_classifier;
    localparam int N_IN  = 49;
    localparam int N_CLS = 10;
    localparam int N_W   = N_IN * N_CLS;
    localparam int LAT   = N_CLS + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   w_ref [N_CLS][N_IN];
    int   b_ref [N_CLS];
    int   d_ref [N_IN];

    fc_classifier_if #(.W1(9), .WW(8), .ACC_W(24)) bus ();

    fc_classifier dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes issued while the DUT is idle; the model follows the same address map.
    task automatic write_w(input int addr, input int val);
        bus.w_we   = 1'b1;
        bus.w_addr = 9'(addr);
        bus.w_data = 8'(val);
        tick();
        bus.w_we = 1'b0;
        if (addr < N_W) w_ref[addr / N_IN][addr % N_IN] = val;
`ifdef FC_BIAS_EN
        else if (addr < N_W + N_CLS) b_ref[addr - N_W] = val;
`endif
    endtask

    task automatic load_weights(input int mode, input int cls, input int val);
        for (int a = 0; a < N_W; a++) begin
            if (mode == 0) write_w(a, val);
            else if (mode == 1) write_w(a, (a / N_IN == cls) ? val : 1);
            else if (mode == 2) write_w(a, (a / N_IN == cls) ? val : 0);
            else write_w(a, int'($urandom_range(255, 0)) - 128);
        end
    endtask

    task automatic model(output int cls, output longint sc);
        longint s [N_CLS];
        logic signed [23:0] t;
        for (int c = 0; c < N_CLS; c++) begin
            s[c] = b_ref[c];
            for (int i = 0; i < N_IN; i++) s[c] += longint'(d_ref[i]) * w_ref[c][i];
            t = s[c][23:0];
            s[c] = longint'(t);
        end
        cls = 0;
        for (int c = 1; c < N_CLS; c++) if (s[c] > s[cls]) cls = c;
        sc = s[cls];
    endtask

    // Streams d_ref; gap idle cycles between samples, optionally with ignored weight writes.
    task automatic run_frame(input int gap, input bit poke, output int lat, output bit busy_mid,
                             output int cls, output longint sc);
        for (int i = 0; i < N_IN; i++) begin
            bus.din       = 9'(d_ref[i]);
            bus.din_valid = 1'b1;
            tick();
            bus.din_valid = 1'b0;
            if (i < N_IN - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.w_we   = poke;
                    bus.w_addr = 9'($urandom_range(N_W - 1, 0));
                    bus.w_data = 8'($urandom);
                    bus.din    = 9'($urandom);
                    tick();
                end
                bus.w_we = 1'b0;
            end
        end
        busy_mid = bus.busy;
        lat = 0;
        while (!bus.done && lat < 60) begin
            bus.din_valid = (lat > 2);
            tick();
            lat++;
        end
        bus.din_valid = 1'b0;
        cls = int'(bus.class_out);
        sc  = longint'(bus.score_out);
    endtask

    task automatic test_reset();
        bus.din = '0; bus.din_valid = 1'b0; bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
        for (int c = 0; c < N_CLS; c++) b_ref[c] = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.class_out !== 4'd0) begin failures++; $display("FAIL reset_class got=%0d exp=0", bus.class_out); end
        checks++; if (bus.score_out !== 24'sd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.score_out); end
    endtask

    task automatic test_all_ones();
        int lat, cls; longint sc; bit bz;
        load_weights(0, 0, 1);
        for (int i = 0; i < N_IN; i++) d_ref[i] = 1;
        run_frame(0, 1'b0, lat, bz, cls, sc);
        checks++; if (bz !== 1'b1) begin failures++; $display("FAIL ones_busy got=%b exp=1", bz); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL ones_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (cls !== 0) begin failures++; $display("FAIL ones_class got=%0d exp=0", cls); end
        checks++; if (sc !== 64'sd49) begin failures++; $display("FAIL ones_score got=%0d exp=49", sc); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", bus.done); end
        repeat (3) tick();
        checks++; if (bus.score_out !== 24'sd49 || bus.class_out !== 4'd0) begin
            failures++; $display("FAIL hold got=%0d/%0d exp=0/49", bus.class_out, bus.score_out); end
    endtask

    task automatic test_class7();
        int lat, cls; longint sc; bit bz;
        load_weights(1, 7, 2);
        for (int i = 0; i < N_IN; i++) d_ref[i] = 3;
        run_frame(0, 1'b0, lat, bz, cls, sc);
        tick();
        checks++; if (cls !== 7) begin failures++; $display("FAIL c7_class got=%0d exp=7", cls); end
        checks++; if (sc !== 64'sd294) begin failures++; $display("FAIL c7_score got=%0d exp=294", sc); end
    endtask

    task automatic test_negative();
        int lat, cls; longint sc; bit bz;
        load_weights(2, 4, -128);
        for (int i = 0; i < N_IN; i++) d_ref[i] = -256;
        run_frame(0, 1'b0, lat, bz, cls, sc);
        tick();
        checks++; if (cls !== 4) begin failures++; $display("FAIL neg_class got=%0d exp=4", cls); end
        checks++; if (sc !== 64'sd1605632) begin failures++; $display("FAIL neg_score got=%0d exp=1605632", sc); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, cls; longint sc; bit bz;
        load_weights(0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            bus.din = 9'sd5; bus.din_valid = 1'b1; tick();
        end
        bus.din_valid = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (bus.busy !== 1'b0 || bus.score_out !== 24'sd0) begin
            failures++; $display("FAIL async_reset busy=%b score=%0d exp=0/0", bus.busy, bus.score_out); end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < N_IN; i++) d_ref[i] = 1;
        run_frame(0, 1'b0, lat, bz, cls, sc);
        tick();
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rst_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (sc !== 64'sd49) begin failures++; $display("FAIL rst_score got=%0d exp=49", sc); end
    endtask

    task automatic test_bias();
        int lat, cls, ecls; longint sc, esc;
        bit bz;
        load_weights(0, 0, 0);
        write_w(N_W + 2, 10);
        for (int i = 0; i < N_IN; i++) d_ref[i] = int'($urandom_range(511, 0)) - 256;
        model(ecls, esc);
        run_frame(0, 1'b0, lat, bz, cls, sc);
        tick();
`ifdef FC_BIAS_EN
        checks++; if (ecls !== 2 || esc !== 64'sd10) begin failures++; $display("FAIL bias_model got=%0d/%0d exp=2/10", ecls, esc); end
`else
        checks++; if (ecls !== 0 || esc !== 64'sd0) begin failures++; $display("FAIL bias_model got=%0d/%0d exp=0/0", ecls, esc); end
`endif
        checks++; if (cls !== ecls) begin failures++; $display("FAIL bias_class got=%0d exp=%0d", cls, ecls); end
        checks++; if (sc !== esc) begin failures++; $display("FAIL bias_score got=%0d exp=%0d", sc, esc); end
    endtask

    task automatic test_gapped();
        int lat0, cls0, lat1, cls1, ecls; longint sc0, sc1, esc;
        bit bz;
        load_weights(3, 0, 0);
        for (int i = 0; i < N_IN; i++) d_ref[i] = int'($urandom_range(511, 0)) - 256;
        model(ecls, esc);
        run_frame(0, 1'b0, lat0, bz, cls0, sc0);
        tick();
        run_frame(2, 1'b1, lat1, bz, cls1, sc1);
        tick();
        checks++; if (cls0 !== ecls || sc0 !== esc) begin
            failures++; $display("FAIL gapless got=%0d/%0d exp=%0d/%0d", cls0, sc0, ecls, esc); end
        checks++; if (cls1 !== ecls || sc1 !== esc) begin
            failures++; $display("FAIL gapped got=%0d/%0d exp=%0d/%0d", cls1, sc1, ecls, esc); end
        checks++; if (lat1 !== LAT) begin failures++; $display("FAIL gapped_latency got=%0d exp=%0d", lat1, LAT); end
    endtask

    task automatic test_back_to_back();
        int lat, cls, ecls; longint sc, esc;
        bit bz;
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 12; j++) write_w(int'($urandom_range(511, 0)), int'($urandom_range(255, 0)) - 128);
            for (int i = 0; i < N_IN; i++) d_ref[i] = int'($urandom_range(511, 0)) - 256;
            model(ecls, esc);
            run_frame(int'($urandom_range(2, 0)), 1'b0, lat, bz, cls, sc);
            tick();
            checks++; if (cls !== ecls || sc !== esc || lat !== LAT) begin
                failures++;
                $display("FAIL frame%0d got=%0d/%0d/lat%0d exp=%0d/%0d/lat%0d", f, cls, sc, lat, ecls, esc, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_class7();
        test_negative();
        test_reset_mid_frame();
        test_bias();
        test_gapped();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fc_classifier.md
FC_CLASSIFIER -- requirements
Module: fc_classifier

Interface
REQ-001 Parameter W1, default 9, signed width of each incoming pooled sample.
REQ-002 Parameter WW, default 8, signed weight width.
REQ-003 Parameter ACC_W, default 24, signed accumulator and score width.
REQ-004 Parameter N_IN, default 49, samples per frame (7x7 pooled map).
REQ-005 Parameter N_CLS, default 10, number of digit classes.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 din  input  W1  signed pooled sample from the max-pooling stage.
REQ-009 din_valid  input  1  din qualifier, driven from the pooling stage's enable.
REQ-010 w_we  input  1  weight write strobe.
REQ-011 w_addr  input  9  weight address = class*N_IN + sample index.
REQ-012 w_data  input  WW  signed weight value.
REQ-013 busy  output  1  high in ACC and ARGMAX.
REQ-014 class_out  output  4  winning class index.
REQ-015 score_out  output  ACC_W  winning accumulator value.
REQ-016 done  output  1  one-cycle result-valid pulse.

Function
REQ-017 Weight RAM SHALL hold N_CLS*N_IN entries; a write SHALL occur only when w_we=1, state=IDLE and w_addr<N_CLS*N_IN, otherwise it is ignored.
REQ-018 FSM states SHALL be IDLE, ACC, ARGMAX, DONE.
REQ-019 IDLE: din_valid=1 SHALL load every acc[c] with init[c]+din*W[c][0], set sample index to 1, go to ACC.
REQ-020 ACC: each din_valid=1 cycle SHALL add din*W[c][k] to acc[c] for all classes in parallel and increment k; din_valid=0 SHALL hold all state.
REQ-021 After the sample with k=N_IN-1 is accepted, the FSM SHALL enter ARGMAX on the next edge.
REQ-022 Products SHALL be full signed W1+WW width, sign-extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W (no saturation).
REQ-023 ARGMAX SHALL compare one class per cycle, index 0..N_CLS-1 (N_CLS cycles), with signed strict greater-than, so ties resolve to the lowest index.
REQ-024 DONE SHALL last exactly one cycle with done=1, class_out/score_out updated, then return to IDLE.
REQ-025 class_out and score_out SHALL hold their last value until the next DONE.
REQ-026 Latency: with the last sample accepted at edge T, done SHALL be high in the cycle after edge T+N_CLS+1 (T+11 at defaults).
REQ-027 din_valid during ARGMAX or DONE SHALL be ignored (upstream stalls on busy); a sample is never partially applied.
REQ-028 init[c] SHALL be 0 unless FC_BIAS_EN is defined.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, k=0, all acc=0, busy=0, done=0, class_out=0, score_out=0, argmax index/best registers=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next valid sample after release starts a new frame.
REQ-031 Reset SHALL NOT clear weight or bias storage.

Configuration
REQ-032 Macro FC_BIAS_EN defined: w_addr N_CLS*N_IN..N_CLS*N_IN+N_CLS-1 (490..499) SHALL write signed bias[c], sign-extended to ACC_W, used as init[c].
REQ-033 Macro FC_BIAS_EN undefined: no bias storage SHALL exist, writes to those addresses are ignored, init[c]=0.

Verification
REQ-034 All weights 1, 49 samples din=1 -> every acc=49, done after 11 cycles, class_out=0 (tie), score_out=49.
REQ-035 W[7][*]=2, others 1, din=3 x49 -> class_out=7, score_out=294.
REQ-036 din=-256, W[c][*]=-128 for c=4, 0 else -> class_out=4, score_out=1605632 (signed arithmetic, no overflow at ACC_W=24).
REQ-037 rst pulsed after 20 samples, then full 49-sample frame with din=1, all weights 1 -> score_out=49 (no residue), weights intact.
REQ-038 FC_BIAS_EN defined, bias[2]=10, all weights 0 -> class_out=2, score_out=10; undefined -> class_out=0, score_out=0.
REQ-039 Gapped din_valid (1 of every 3 cycles) and w_we during ACC -> results identical to gapless run; ACC-state weight writes have no effect.
